// File: rtl/dp_ram_stream_if.sv
// dp_ram_stream_if: write port, read-request port and read-return bus.
// master: drives writes, read requests and rd_ready; slave: the RAM.
interface dp_ram_stream_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 256
);
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    rd_req_valid;
    logic                    rd_req_ready;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [DATA_WIDTH-1:0]   rd_data;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data,
        output rd_req_valid, rd_addr, rd_ready,
        input  rd_req_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data,
        input  rd_req_valid, rd_addr, rd_ready,
        output rd_req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/dp_ram_stream.sv
// dp_ram_stream: dual-port RAM, byte-masked writes, RD_LATENCY read pipe,
// fall-through return FIFO and credit-gated read requests.
// Ports: clk, rst (sync, active-high), bus (dp_ram_stream_if.slave).
module dp_ram_stream #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 256,
    parameter int DATA_DEPTH = 1024,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1
) (
    input  logic           clk,
    input  logic           rst,
    dp_ram_stream_if.slave bus
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int FD   = RD_LATENCY + 1;
    localparam int PW   = $clog2(FD);
    localparam int CW   = $clog2(RD_LATENCY + 2);

    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [CW-1:0]       CREDITS  = CW'(FD);
    localparam logic [PW-1:0]       PTR_LAST = PW'(FD - 1);

    logic [DATA_WIDTH-1:0] r_mem  [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] r_pd   [RD_LATENCY];
    logic [RD_LATENCY-1:0] r_pv;
    logic [DATA_WIDTH-1:0] r_fifo [FD];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_fcnt;
    logic [CW-1:0]         r_out;
    logic [DATA_WIDTH-1:0] r_hold;

    logic                  w_wr_act;
    logic                  w_rd_rdy;
    logic                  w_acc;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_arr_vld;
    logic [DATA_WIDTH-1:0] w_arr_data;
    logic                  w_empty;
    logic                  w_vld;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_deq;

    assign w_wr_act = bus.wr_en & ~rst & ({1'b0, bus.wr_addr} < DEPTH_L);

    // Credits bound everything in the pipe plus the FIFO to FD words,
    // so the FIFO can never overflow.
    assign w_rd_rdy = ~rst & (r_out < CREDITS);
    assign w_acc    = bus.rd_req_valid & w_rd_rdy;

    always_comb begin
        w_rd_word = r_mem[bus.rd_addr];
        for (int b = 0; b < BE_W; b++) begin
            if ((BYPASS != 0) && w_wr_act && bus.wr_be[b] &&
                (bus.wr_addr == bus.rd_addr)) begin
                w_rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_act) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.wr_be[b]) begin
                    r_mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_pd[0] <= w_rd_word;
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_pd[i] <= r_pd[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_acc;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    assign w_arr_vld  = r_pv[RD_LATENCY-1];
    assign w_arr_data = r_pd[RD_LATENCY-1];
    assign w_empty    = (r_fcnt == '0);

    // Fall-through: an arriving word is the head when the FIFO is empty.
    assign w_vld  = ~rst & (~w_empty | w_arr_vld);
    assign w_head = w_empty ? w_arr_data : r_fifo[r_rptr];
    assign w_pop  = w_vld & bus.rd_ready;
    assign w_push = w_arr_vld & ~(w_empty & w_pop);
    assign w_deq  = w_pop & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_arr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
            r_out  <= '0;
            r_hold <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_deq);
            r_out  <= r_out + CW'(w_acc) - CW'(w_pop);
            if (w_vld) begin
                r_hold <= w_head;
            end
        end
    end

    assign bus.rd_req_ready = w_rd_rdy;
    assign bus.rd_valid     = w_vld;
    assign bus.rd_data      = rst ? '0 : (w_vld ? w_head : r_hold);
endmodule

// File: tb/tb_dp_ram_stream.sv
// tb_dp_ram_stream: two instances (L=2/BYPASS=1, L=3/BYPASS=0) share
// one stimulus stream and are checked against a request-queue model.
module tb_dp_ram_stream;
    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 48;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_req_valid;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;

    logic [1:0]    o_rdy;
    logic [1:0]    o_vld;
    logic [DW-1:0] o_data [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dp_ram_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_if ();
        assign u_if.wr_en        = wr_en;
        assign u_if.wr_addr      = wr_addr;
        assign u_if.wr_be        = wr_be;
        assign u_if.wr_data      = wr_data;
        assign u_if.rd_req_valid = rd_req_valid;
        assign u_if.rd_addr      = rd_addr;
        assign u_if.rd_ready     = rd_ready;
        assign o_rdy[g]          = u_if.rd_req_ready;
        assign o_vld[g]          = u_if.rd_valid;
        assign o_data[g]         = u_if.rd_data;

        dp_ram_stream #(
            .ADDR_WIDTH(AW),
            .DATA_WIDTH(DW),
            .DATA_DEPTH(DEPTH),
            .RD_LATENCY(g == 0 ? 2 : 3),
            .BYPASS    (g == 0 ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(u_if.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
        bit            c;
    } exp_t;

    exp_t          q [2][$];
    logic [DW-1:0] mem_m [64];
    int            cyc;
    int            n_chk;
    int            n_err;
    int            dut_acc [2];
    int            dut_pop [2];
    logic [DW-1:0] last_pop [2];

    function automatic int lat(int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic bit byp(int k);
        return k == 0;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: compare at the negedge, then advance the model at posedge.
    task automatic cycle();
        bit            acc [2];
        bit            pop [2];
        logic [DW-1:0] rv  [2];
        bit            er;
        bit            ev;
        bit            wr_ok;
        @(negedge clk);
        wr_ok = wr_en && !rst && (int'(wr_addr) < DEPTH);
        for (int k = 0; k < 2; k++) begin
            er = !rst && (q[k].size() < lat(k) + 1);
            ev = !rst && (q[k].size() > 0) && (q[k][0].t <= cyc);
            chk($sformatf("rd_req_ready[%0d]@%0d", k, cyc), DW'(o_rdy[k]), DW'(er));
            chk($sformatf("rd_valid[%0d]@%0d", k, cyc), DW'(o_vld[k]), DW'(ev));
            if (ev && q[k][0].c) begin
                chk($sformatf("rd_data[%0d]@%0d", k, cyc), o_data[k], q[k][0].d);
            end
            if (rd_req_valid && o_rdy[k]) dut_acc[k]++;
            if (o_vld[k] && rd_ready) begin
                dut_pop[k]++;
                last_pop[k] = o_data[k];
            end
            acc[k] = rd_req_valid && er;
            pop[k] = ev && rd_ready;
            rv[k]  = mem_m[rd_addr];
            if (byp(k) && wr_ok && (wr_addr == rd_addr)) begin
                for (int b = 0; b < BW; b++) begin
                    if (wr_be[b]) rv[k][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                q[k].delete();
            end else begin
                if (pop[k]) void'(q[k].pop_front());
                if (acc[k]) begin
                    q[k].push_back('{d: rv[k], t: cyc + lat(k),
                                     c: (int'(rd_addr) < DEPTH)});
                end
            end
        end
        if (wr_ok) begin
            for (int b = 0; b < BW; b++) begin
                if (wr_be[b]) mem_m[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle();
        wr_en        = 1'b0;
        wr_be        = '0;
        rd_req_valid = 1'b0;
    endtask

    task automatic clr_counts();
        for (int k = 0; k < 2; k++) begin
            dut_acc[k] = 0;
            dut_pop[k] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
        rst      = 1'b1;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        rd_ready = 1'b1;
        idle();
        clr_counts();
        repeat (3) cycle();

        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_rd_data[%0d]", k), o_data[k], '0);
        end

        // Preload every in-range word.
        for (int a = 0; a < DEPTH; a++) begin
            wr_en   = 1'b1;
            wr_be   = '1;
            wr_addr = AW'(a);
            if (a < 8)       w = DW'(a * 'h11);
            else if (a == 9) w = {BW{8'hAA}};
            else             w = {$urandom, $urandom};
            wr_data = w;
            cycle();
        end
        idle();

        // Streaming read of 0..7.
        clr_counts();
        rd_ready = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd_req_valid = 1'b1;
            rd_addr      = AW'(a);
            cycle();
        end
        idle();
        repeat (6) cycle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stream_pops[%0d]", k), DW'(dut_pop[k]), 8);
            chk($sformatf("stream_last[%0d]", k), last_pop[k], 'h77);
        end

        // Backpressure: only RD_LATENCY+1 accepts while stalled.
        clr_counts();
        rd_ready     = 1'b0;
        rd_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = AW'(i + 16);
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stall_acc[%0d]", k), DW'(dut_acc[k]), DW'(lat(k) + 1));
        end
        clr_counts();
        rd_req_valid = 1'b0;
        rd_ready     = 1'b1;
        repeat (8) cycle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stall_pops[%0d]", k), DW'(dut_pop[k]), DW'(lat(k) + 1));
            chk($sformatf("stall_last[%0d]", k), last_pop[k], mem_m[16 + lat(k)]);
        end

        // Byte enables.
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_be   = '1;
        wr_data = '1;
        cycle();
        wr_be   = BW'(8'h05);
        wr_data = '0;
        cycle();
        idle();
        rd_req_valid = 1'b1;
        rd_addr      = AW'(5);
        cycle();
        idle();
        repeat (5) cycle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("byte_en[%0d]", k), last_pop[k], 64'hFFFF_FFFF_FF00_FF00);
        end

        // Read-during-write on address 9, then read it again.
        wr_en        = 1'b1;
        wr_addr      = AW'(9);
        wr_be        = '1;
        wr_data      = {BW{8'h55}};
        rd_req_valid = 1'b1;
        rd_addr      = AW'(9);
        cycle();
        idle();
        repeat (5) cycle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rdw_same[%0d]", k), last_pop[k],
                byp(k) ? {BW{8'h55}} : {BW{8'hAA}});
        end
        rd_req_valid = 1'b1;
        cycle();
        idle();
        repeat (5) cycle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rdw_next[%0d]", k), last_pop[k], {BW{8'h55}});
        end

        // Reset with reads in flight and buffered.
        rd_ready     = 1'b0;
        rd_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(10 + i);
            cycle();
        end
        rd_req_valid = 1'b0;
        rst          = 1'b1;
        cycle();
        rst      = 1'b0;
        rd_ready = 1'b1;
        clr_counts();
        repeat (8) cycle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_no_return[%0d]", k), DW'(dut_pop[k]), 0);
        end
        rd_req_valid = 1'b1;
        rd_addr      = AW'(3);
        cycle();
        idle();
        repeat (5) cycle();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_keep_mem[%0d]", k), last_pop[k], 'h33);
        end

        // Random traffic including out-of-range addresses and resets.
        for (int i = 0; i < 1500; i++) begin
            wr_en        = ($urandom_range(0, 1) == 1);
            wr_addr      = AW'($urandom_range(0, 63));
            wr_be        = BW'($urandom);
            wr_data      = {$urandom, $urandom};
            rd_req_valid = ($urandom_range(0, 9) < 7);
            rd_addr      = ($urandom_range(0, 3) == 0) ? wr_addr
                                                       : AW'($urandom_range(0, 63));
            rd_ready     = ($urandom_range(0, 9) < 6);
            rst          = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst      = 1'b0;
        rd_ready = 1'b1;
        idle();
        repeat (10) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
